udp_pattern_gen: RTL and testbench
==================================

// Module: udp_pattern_gen
//
// PURPOSE
//  Parametrised multi-channel test-pattern source for the UDP transmit path.
//  Emits one N_CH x DW sample per programmable period of clk_en strobes.
//  Patterns are square, ramp or channel-ID; PRBS is optional.
//  Output uses a valid/ready handshake with sop/eop packet framing.
//  Sits in front of the UDP packetiser and stands in for the ADC I/Q stream
//  during link bring-up.
//
// PARAMETERS
//  N_CH      2   number of channels (ch0 in LSBs of out_dat)
//  DW        16  bits per channel sample
//  PERIOD_W  16  width of period input
//  PKT_W     12  width of pkt_len input
//
// PORTS
//  clk       in   1          system clock
//  rst_n     in   1          asynchronous reset, active low
//  clk_en    in   1          sample-rate strobe; the period counter advances only when high
//  enable    in   1          generator run
//  mode      in   2          0 SQUARE, 1 RAMP, 2 CHAN_ID, 3 PRBS
//  period    in   PERIOD_W   sample every period+1 clk_en strobes
//  pkt_len   in   PKT_W      samples per packet
//  out_dat   out  N_CH*DW    sample data
//  valid     out  1          out_dat/sop/eop are valid
//  ready     in   1          downstream accept
//  sop       out  1          first sample of packet
//  eop       out  1          last sample of packet
//  drop_cnt  out  16         dropped samples, saturating
//
// BEHAVIOUR
//  - Reset: out_dat=0, valid=0, sop=0, eop=0, drop_cnt=0, period cnt=0, pkt idx=0.
//    Square state =0x7FFF (MSB clear, rest set); ramp base=0; LFSR ch c seed =c+1.
//  - Config latch: mode, period and pkt_len are latched on the cycle enable is
//    seen low->high. The same edge reinitialises pattern state and packet index
//    to their reset values. Changes while enable is high are ignored.
//  - Period counter: runs on clk_en & enable.
//    - cnt==latched period: a sample is due ("tick") and cnt wraps to 0.
//    - Otherwise cnt+1.
//    - period=0: tick on every clk_en strobe.
//  - Tick handling:
//    - If !valid or (valid & ready) in the same cycle: load the sample into the
//      output register and assert valid on the next clk edge (1-cycle latency).
//    - Otherwise the sample is dropped and drop_cnt increments, saturating at 0xFFFF.
//  - Pattern state advances on every tick, dropped or not, so drops appear as gaps.
//  - valid rules:
//    - Holds until accepted (valid & ready).
//    - Clears after accept unless a new sample loads in the same cycle.
//    - out_dat/sop/eop are stable while valid & !ready.
//  - Patterns, per tick:
//    - SQUARE: every channel = state; state inverts each tick (0x7FFF, 0x8000, ...).
//    - RAMP: ch c = base+c mod 2^DW; base+1 per tick, wraps.
//    - CHAN_ID: ch c = {c[7:0], seq[7:0]} for DW=16. seq+1 per tick.
//      For other DW: c in the upper half, seq in the lower half.
//  - Framing:
//    - Packet index advances on loaded samples only.
//    - sop when idx==0; eop when idx==pkt_len-1, then idx wraps to 0.
//    - pkt_len 0 or 1: sop=eop=1 on every sample.
//  - enable low: no new ticks, cnt held at 0. A pending valid sample is still
//    presented until accepted.
//  - clk_en low: pattern state and period counter frozen. The handshake still
//    runs on clk.
//  - rst_n asserted mid-packet: all state returns to reset values immediately.
//    No eop is emitted.
//
// CONFIGURATION
//  UDP_TPG_PRBS_EN
//   - defined: mode 3 = PRBS-15 (x^15+x^14+1), one LFSR per channel, one step
//     per tick. ch c = LFSR state zero-extended/truncated to DW.
//   - undefined: no LFSR logic; mode 3 behaves as SQUARE.
//
// STRUCTURE
//  - Package udp_tpg_pkg: tpg_mode_e enum (SQUARE/RAMP/CHAN_ID/PRBS), SQ_INIT=0x7FFF,
//    PRBS15 tap constants, seed function seed(c)=c+1.
//  - Sub-module tpg_lfsr15 (step, init, seed -> state), generated per channel
//    under UDP_TPG_PRBS_EN.
//
// TESTING
//  1. enable=1, SQUARE, period=20, clk_en=1, ready=1: ticks every 21 clks.
//     out_dat alternates 0x7FFF7FFF / 0x80008000.
//  2. RAMP, N_CH=2, period=0, pkt_len=4, ready=1: ch0/ch1 = 0/1, 1/2, 2/3, ...
//     sop on samples 0,4,8; eop on samples 3,7,11.
//  3. RAMP, period=0, ready=0 for 5 ticks: first sample held stable and the
//     following 4 ticks are dropped (drop_cnt=4); drop_cnt=4 after the window.
//     After ready=1, ramp resumes at base 5.
//  4. Change mode and period while enable=1: no effect. Toggle enable 1->0->1:
//     new config applies and pattern restarts at its reset value.
//  5. clk_en=1 every 4th clk, period=1: a tick every 8 clks. Ticks stop while
//     clk_en is low; valid is still accepted.
//  6. With UDP_TPG_PRBS_EN, mode 3: ch0 sequence matches the PRBS-15 model from
//     seed 1. Without the macro, mode 3 output equals SQUARE.

Source files
------------

// File: rtl/udp_tpg_pkg.sv
// Shared types and constants for the UDP test-pattern generator.
// Holds the pattern-mode enum, the square-wave start value and PRBS-15 helpers.
package udp_tpg_pkg;

  typedef enum logic [1:0] {
    ModeSquare = 2'd0,
    ModeRamp   = 2'd1,
    ModeChanId = 2'd2,
    ModePrbs   = 2'd3
  } tpg_mode_e;

  localparam logic [15:0] SQ_INIT = 16'h7FFF;

  // x^15 + x^14 + 1, Fibonacci form
  localparam int unsigned PRBS15_TAP_HI = 14;
  localparam int unsigned PRBS15_TAP_LO = 13;

  function automatic logic [14:0] seed(input int unsigned c);
    return 15'(c + 32'd1);
  endfunction

  function automatic logic [14:0] prbs15_step(input logic [14:0] s);
    return {s[13:0], s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO]};
  endfunction

endpackage

// File: rtl/tpg_lfsr15.sv
// Single PRBS-15 generator. state_o shows the value to emit this cycle,
// already reflecting a same-cycle init back to the seed.
module tpg_lfsr15
  import udp_tpg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  input  logic        init_i,
  input  logic [14:0] seed_i,
  output logic [14:0] state_o
);

  logic [14:0] state_q, state_d, state_cur;

  always_comb begin
    state_cur = init_i ? seed_i : state_q;
    state_d   = step_i ? prbs15_step(state_cur) : state_cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= seed_i;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_cur;

endmodule

// File: rtl/udp_pattern_gen.sv
// Multi-channel test-pattern source with valid/ready handshake and sop/eop framing.
// Define UDP_TPG_PRBS_EN to build per-channel PRBS-15 for mode 3; otherwise mode 3 is SQUARE.
module udp_pattern_gen
  import udp_tpg_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned DW       = 16,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned PKT_W    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [PERIOD_W-1:0]  period,
  input  logic [PKT_W-1:0]     pkt_len,
  output logic [N_CH*DW-1:0]   out_dat,
  output logic                 valid,
  input  logic                 ready,
  output logic                 sop,
  output logic                 eop,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned HW = DW / 2;
  localparam int unsigned LW = DW - HW;
  localparam logic [DW-1:0] SqInit = (DW == 16) ? DW'(SQ_INIT) : {1'b0, {(DW-1){1'b1}}};

  logic                en_q;
  tpg_mode_e           mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [PKT_W-1:0]    pkt_len_q, pkt_len_d, idx_q, idx_d;
  logic [DW-1:0]       sq_q, sq_d, ramp_q, ramp_d;
  logic [LW-1:0]       seq_q, seq_d;
  logic [N_CH*DW-1:0]  out_dat_q, out_dat_d;
  logic                valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [15:0]         drop_q, drop_d;

  logic                rise, tick, load, drop, last;
  logic [DW-1:0]       sq_cur, ramp_cur;
  logic [LW-1:0]       seq_cur;
  logic [PKT_W-1:0]    idx_cur;
  logic [N_CH*DW-1:0]  sample;
  logic [DW-1:0]       lfsr_dat [N_CH];

  // Rising enable latches config and restarts pattern/framing in the same cycle,
  // so a tick on that cycle already sees the fresh values.
  assign rise = enable & ~en_q;

`ifdef UDP_TPG_PRBS_EN
  for (genvar g = 0; g < N_CH; g++) begin : g_lfsr
    localparam logic [14:0] Seed = seed(g);
    logic [14:0] st;

    tpg_lfsr15 u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .step_i (tick),
      .init_i (rise),
      .seed_i (Seed),
      .state_o(st)
    );

    assign lfsr_dat[g] = DW'(st);
  end
`else
  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      lfsr_dat[c] = '0;
    end
  end
`endif

  always_comb begin
    mode_d    = rise ? tpg_mode_e'(mode) : mode_q;
    period_d  = rise ? period : period_q;
    pkt_len_d = rise ? pkt_len : pkt_len_q;
    sq_cur    = rise ? SqInit : sq_q;
    ramp_cur  = rise ? '0 : ramp_q;
    seq_cur   = rise ? '0 : seq_q;
    idx_cur   = rise ? '0 : idx_q;

    tick = enable & clk_en & (cnt_q == period_d);

    if (!enable) begin
      cnt_d = '0;
    end else if (clk_en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    sample = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      case (mode_d)
        ModeRamp:   sample[c*DW +: DW] = ramp_cur + DW'(c);
        ModeChanId: sample[c*DW +: DW] = {HW'(c), seq_cur};
`ifdef UDP_TPG_PRBS_EN
        ModePrbs:   sample[c*DW +: DW] = lfsr_dat[c];
`endif
        default:    sample[c*DW +: DW] = sq_cur;
      endcase
    end

    // Pattern state advances on every tick, including dropped ones.
    sq_d   = tick ? ~sq_cur : sq_cur;
    ramp_d = tick ? ramp_cur + 1'b1 : ramp_cur;
    seq_d  = tick ? seq_cur + 1'b1 : seq_cur;

    last = (pkt_len_d <= PKT_W'(1)) || (idx_cur == pkt_len_d - PKT_W'(1));
    load = tick & (~valid_q | ready);
    drop = tick & valid_q & ~ready;

    out_dat_d = out_dat_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    valid_d   = valid_q;
    idx_d     = idx_cur;
    if (load) begin
      out_dat_d = sample;
      sop_d     = (idx_cur == '0);
      eop_d     = last;
      valid_d   = 1'b1;
      idx_d     = last ? '0 : idx_cur + 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      mode_q    <= ModeSquare;
      period_q  <= '0;
      pkt_len_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      sq_q      <= SqInit;
      ramp_q    <= '0;
      seq_q     <= '0;
      out_dat_q <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      en_q      <= enable;
      mode_q    <= mode_d;
      period_q  <= period_d;
      pkt_len_q <= pkt_len_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sq_q      <= sq_d;
      ramp_q    <= ramp_d;
      seq_q     <= seq_d;
      out_dat_q <= out_dat_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      drop_q    <= drop_d;
    end
  end

  assign out_dat  = out_dat_q;
  assign valid    = valid_q;
  assign sop      = sop_q;
  assign eop      = eop_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_udp_pattern_gen.sv
// Directed self-checking bench for udp_pattern_gen (N_CH=2, DW=16).
module tb_udp_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, enable, ready;
  logic [1:0]  mode;
  logic [15:0] period;
  logic [11:0] pkt_len;
  logic [31:0] out_dat;
  logic        valid, sop, eop;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  udp_pattern_gen #(
    .N_CH    (2),
    .DW      (16),
    .PERIOD_W(16),
    .PKT_W   (12)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .enable  (enable),
    .mode    (mode),
    .period  (period),
    .pkt_len (pkt_len),
    .out_dat (out_dat),
    .valid   (valid),
    .ready   (ready),
    .sop     (sop),
    .eop     (eop),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic go_idle();
    enable = 1'b0;
    ready  = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b0; enable = 1'b0; ready = 1'b0;
    mode = 2'd0; period = 16'd0; pkt_len = 12'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_dat !== 32'h0 || valid !== 1'b0 || sop !== 1'b0 || eop !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: dat=%h v=%b sop=%b eop=%b, want 0/0/0/0", out_dat, valid, sop, eop);
    end
    checks++;
    if (drop_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_drop: got %h want 0000", drop_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid: got %b want 0", valid);
    end
  endtask

  task automatic test_square();
    logic [31:0] exp;
    int n;
    go_idle();
    mode = 2'd0; period = 16'd20; pkt_len = 12'd4;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (n < 100) begin
        @(negedge clk);
        n++;
        if (valid === 1'b1) break;
      end
      exp = (k % 2 == 0) ? 32'h7FFF7FFF : 32'h80008000;
      checks++;
      if (n != 21) begin
        errors++;
        $display("FAIL square_interval[%0d]: got %0d clks want 21", k, n);
      end
      checks++;
      if (out_dat !== exp || sop !== (k == 0)) begin
        errors++;
        $display("FAIL square_data[%0d]: got %h sop=%b want %h sop=%b", k, out_dat, sop, exp, k == 0);
      end
    end
  endtask

  task automatic test_ramp_frame();
    logic [31:0] exp;
    go_idle();
    mode = 2'd1; period = 16'd0; pkt_len = 12'd4;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp = {16'(k + 1), 16'(k)};
      checks++;
      if (valid !== 1'b1 || out_dat !== exp || sop !== (k % 4 == 0) || eop !== (k % 4 == 3)) begin
        errors++;
        $display("FAIL ramp_frame[%0d]: v=%b dat=%h sop=%b eop=%b want v=1 dat=%h sop=%b eop=%b",
                 k, valid, out_dat, sop, eop, exp, k % 4 == 0, k % 4 == 3);
      end
    end
  endtask

  task automatic test_drop();
    go_idle();
    mode = 2'd1; period = 16'd0; pkt_len = 12'd4;
    ready = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || out_dat !== 32'h00010000 || sop !== 1'b1) begin
        errors++;
        $display("FAIL drop_hold[%0d]: v=%b dat=%h sop=%b want v=1 dat=00010000 sop=1",
                 k, valid, out_dat, sop);
      end
    end
    checks++;
    if (drop_cnt !== 16'd4) begin
      errors++;
      $display("FAIL drop_count: got %0d want 4", drop_cnt);
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || out_dat !== 32'h00060005 || sop !== 1'b0 || drop_cnt !== 16'd4) begin
      errors++;
      $display("FAIL drop_resume: v=%b dat=%h sop=%b drop=%0d want v=1 dat=00060005 sop=0 drop=4",
               valid, out_dat, sop, drop_cnt);
    end
  endtask

  // Runs straight on from test_drop: ramp at base 6 next, period 0.
  task automatic test_config();
    int n;
    mode = 2'd0; period = 16'd5;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || out_dat !== 32'h00070006) begin
      errors++;
      $display("FAIL cfg_ignored0: v=%b dat=%h want v=1 dat=00070006", valid, out_dat);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || out_dat !== 32'h00080007) begin
      errors++;
      $display("FAIL cfg_ignored1: v=%b dat=%h want v=1 dat=00080007", valid, out_dat);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL cfg_disable_valid: got %b want 0", valid);
    end
    enable = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (valid === 1'b1) break;
    end
    checks++;
    if (n != 6 || out_dat !== 32'h7FFF7FFF || sop !== 1'b1) begin
      errors++;
      $display("FAIL cfg_apply: clks=%0d dat=%h sop=%b want clks=6 dat=7fff7fff sop=1", n, out_dat, sop);
    end
  endtask

  task automatic test_clk_en();
    logic        exp_v;
    logic [15:0] b;
    go_idle();
    mode = 2'd1; period = 16'd1; pkt_len = 12'd4;
    enable = 1'b1;
    for (int n = 0; n < 24; n++) begin
      clk_en = (n % 4 == 0);
      @(negedge clk);
      exp_v = (n == 4) || (n == 12) || (n == 20);
      b = 16'((n - 4) / 8);
      checks++;
      if (valid !== exp_v || (exp_v && out_dat !== {b + 16'd1, b})) begin
        errors++;
        $display("FAIL clk_en[%0d]: v=%b dat=%h want v=%b dat=%h", n, valid, out_dat, exp_v,
                 {b + 16'd1, b});
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_chan_id();
    logic [31:0] exp;
    go_idle();
    mode = 2'd2; period = 16'd0; pkt_len = 12'd1;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp = {8'h01, 8'(k), 8'h00, 8'(k)};
      checks++;
      if (valid !== 1'b1 || out_dat !== exp || sop !== 1'b1 || eop !== 1'b1) begin
        errors++;
        $display("FAIL chan_id[%0d]: v=%b dat=%h sop=%b eop=%b want v=1 dat=%h sop=1 eop=1",
                 k, valid, out_dat, sop, eop, exp);
      end
    end
  endtask

  task automatic test_prbs();
    logic [31:0] exp;
    logic [14:0] s0, s1;
    go_idle();
    mode = 2'd3; period = 16'd0; pkt_len = 12'd0;
    enable = 1'b1;
    s0 = 15'd1;
    s1 = 15'd2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
`ifdef UDP_TPG_PRBS_EN
      exp = {1'b0, s1, 1'b0, s0};
`else
      exp = (k % 2 == 0) ? 32'h7FFF7FFF : 32'h80008000;
`endif
      checks++;
      if (valid !== 1'b1 || out_dat !== exp) begin
        errors++;
        $display("FAIL prbs[%0d]: v=%b dat=%h want v=1 dat=%h", k, valid, out_dat, exp);
      end
      s0 = {s0[13:0], s0[14] ^ s0[13]};
      s1 = {s1[13:0], s1[14] ^ s1[13]};
    end
  endtask

  task automatic test_reset_midpacket();
    go_idle();
    mode = 2'd1; period = 16'd0; pkt_len = 12'd4;
    ready = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || out_dat !== 32'h0 || sop !== 1'b0 || eop !== 1'b0 || drop_cnt !== 16'h0) begin
      errors++;
      $display("FAIL midreset: v=%b dat=%h sop=%b eop=%b drop=%0d want all 0",
               valid, out_dat, sop, eop, drop_cnt);
    end
    enable = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || eop !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: v=%b eop=%b want 0/0", valid, eop);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_ramp_frame();
    test_drop();
    test_config();
    test_clk_en();
    test_chan_id();
    test_prbs();
    test_reset_midpacket();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
